// File: rtl/irq_ctrl_pkg.sv
// Shared constants and FSM encoding for the irq_ctrl interrupt controller.
package irq_ctrl_pkg;
    localparam int NUM_IRQ = 8;
    localparam int VEC_W = 3;
    localparam logic [NUM_IRQ-1:0] MASK_RST_DEFAULT = 8'hFF;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ASSERT  = 2'd1,
        SERVICE = 2'd2
    } state_t;
endpackage

// File: rtl/irq_prio_enc.sv
// Combinational lowest-index-wins priority encoder with a valid flag.
module irq_prio_enc
    import irq_ctrl_pkg::*;
(
    input  logic [NUM_IRQ-1:0] req,
    output logic [VEC_W-1:0]   vec,
    output logic               valid
);
    always_comb begin
        vec   = '0;
        valid = 1'b0;
        // Scan downward so the lowest set index is the last assignment.
        for (int i = NUM_IRQ - 1; i >= 0; i--) begin
            if (req[i]) begin
                vec   = VEC_W'(i);
                valid = 1'b1;
            end
        end
    end
endmodule

// File: rtl/irq_ctrl.sv
// Eight-input priority interrupt controller feeding the CPU interrupt/irq inputs.
// Define IRQ_CTRL_EDGE_EN for edge-triggered request capture (level-sensitive otherwise).
module irq_ctrl #(
    parameter int NUM_IRQ = irq_ctrl_pkg::NUM_IRQ,
    parameter logic [NUM_IRQ-1:0] MASK_RST = irq_ctrl_pkg::MASK_RST_DEFAULT
) (
    input  logic                           clock,
    input  logic                           reset_n,
    input  logic [NUM_IRQ-1:0]             req,
    input  logic                           mask_we,
    input  logic [NUM_IRQ-1:0]             mask_wd,
    input  logic                           ack,
    input  logic                           eoi,
    output logic                           interrupt,
    output logic [irq_ctrl_pkg::VEC_W-1:0] irq,
    output logic [NUM_IRQ-1:0]             pending,
    output logic [NUM_IRQ-1:0]             in_service,
    output logic [NUM_IRQ-1:0]             mask
);
    import irq_ctrl_pkg::*;

    state_t state, state_nxt;
    logic [VEC_W-1:0]   win_vec;
    logic               win_vld;
    logic               take;
    logic [NUM_IRQ-1:0] clr;
    logic [NUM_IRQ-1:0] set;

    irq_prio_enc u_enc (
        .req   (pending & ~mask),
        .vec   (win_vec),
        .valid (win_vld)
    );

    assign take = (state == ASSERT) && ack;
    // ack clears the vector the CPU saw this cycle, not the current winner.
    assign clr  = take ? (NUM_IRQ'(1) << irq) : '0;

`ifdef IRQ_CTRL_EDGE_EN
    logic [NUM_IRQ-1:0] req_hist;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) req_hist <= '0;
        else          req_hist <= req;
    end

    assign set = req & ~req_hist;
`else
    assign set = req;
`endif

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (win_vld) state_nxt = ASSERT;
            ASSERT: begin
                if (ack)           state_nxt = SERVICE;
                else if (!win_vld) state_nxt = IDLE;
            end
            SERVICE: if (eoi) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_nxt;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            interrupt  <= 1'b0;
            irq        <= '0;
            pending    <= '0;
            in_service <= '0;
            mask       <= MASK_RST;
        end else begin
            // A same-edge set overrides the ack clear.
            pending   <= (pending & ~clr) | set;
            interrupt <= (state_nxt == ASSERT);
            if (state_nxt == ASSERT && win_vld) irq <= win_vec;
            if (take)                            in_service <= clr;
            else if (state == SERVICE && eoi)    in_service <= '0;
            if (mask_we) mask <= mask_wd;
        end
    end
endmodule
